// File: rtl/ext_tran_master.sv
// ---------------------------------------------------------------------------
// ext_tran_master
//
// Runs one external transaction request (from the FPGA register bridge) as a
// single Wishbone classic master cycle. The result is reported back through a
// sticky ready/err/timeout status that holds until the bridge clears it.
//
// Ports:
//   clk_i, reset_i           clock, asynchronous active-low reset
//   bus_gnt_i                1 = this master owns the SoC bus
//   ext_tran_start_i         one-cycle request pulse
//   ext_tran_write_i         1 = write, 0 = read
//   ext_tran_size_i          00 byte, 01 half, 10 word, 11 illegal
//   ext_tran_addr_i          byte address
//   ext_tran_data_i          right-aligned write data
//   ext_tran_clear_i         acknowledge result, return to idle
//   ext_tran_data_o          right-aligned, zero-extended read data
//   ext_tran_ready_o         transaction finished (sticky)
//   ext_tran_err_o           finished with bus error / misalign / bad size
//   ext_tran_timeout_o       finished by timeout
//   wb_*                     Wishbone classic master interface
// ---------------------------------------------------------------------------
module ext_tran_master #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_W           = 11
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            bus_gnt_i,
    input  logic            ext_tran_start_i,
    input  logic            ext_tran_write_i,
    input  logic [1:0]      ext_tran_size_i,
    input  logic [31:0]     ext_tran_addr_i,
    input  logic [31:0]     ext_tran_data_i,
    input  logic            ext_tran_clear_i,
    output logic [31:0]     ext_tran_data_o,
    output logic            ext_tran_ready_o,
    output logic            ext_tran_err_o,
    output logic            ext_tran_timeout_o,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic            wb_we_o,
    output logic [31:0]     wb_adr_o,
    output logic [31:0]     wb_dat_o,
    output logic [3:0]      wb_sel_o,
    input  logic [31:0]     wb_dat_i,
    input  logic            wb_ack_i,
    input  logic            wb_err_i
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_GNT = 2'd1,
        BUS      = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [1:0]      size_q, size_d;
    logic            we_q, we_d;
    logic            cyc_q, cyc_d;
    logic            bus_we_q, bus_we_d;
    logic [31:0]     adr_q, adr_d;
    logic [31:0]     bus_dat_q, bus_dat_d;
    logic [3:0]      sel_q, sel_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            ready_q, ready_d;
    logic            err_q, err_d;
    logic            timeout_q, timeout_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    logic            req_illegal;
    logic [3:0]      lane_sel;
    logic [31:0]     lane_dat;
    logic [31:0]     lane_rdata;

    // Misaligned half/word accesses and the reserved size code are rejected
    // before any bus activity.
    always_comb begin
        req_illegal = 1'b0;
        case (ext_tran_size_i)
            2'b00:   req_illegal = 1'b0;
            2'b01:   req_illegal = ext_tran_addr_i[0];
            2'b10:   req_illegal = (ext_tran_addr_i[1:0] != 2'b00);
            default: req_illegal = 1'b1;
        endcase
    end

    // Byte lane placement of the captured request: write data is replicated
    // across lanes so the selected lane always carries the right bits.
    always_comb begin
        lane_sel = 4'b1111;
        lane_dat = wdata_q;
        case (size_q)
            2'b00: begin
                lane_sel = 4'b0001 << addr_q[1:0];
                lane_dat = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                lane_sel = addr_q[1] ? 4'b1100 : 4'b0011;
                lane_dat = {2{wdata_q[15:0]}};
            end
            default: begin
                lane_sel = 4'b1111;
                lane_dat = wdata_q;
            end
        endcase
    end

    // Read data: shift the addressed lanes down to bit 0 and zero-extend.
    always_comb begin
        lane_rdata = wb_dat_i;
        case (size_q)
            2'b00: begin
                case (addr_q[1:0])
                    2'b00:   lane_rdata = {24'h0, wb_dat_i[7:0]};
                    2'b01:   lane_rdata = {24'h0, wb_dat_i[15:8]};
                    2'b10:   lane_rdata = {24'h0, wb_dat_i[23:16]};
                    default: lane_rdata = {24'h0, wb_dat_i[31:24]};
                endcase
            end
            2'b01:   lane_rdata = addr_q[1] ? {16'h0, wb_dat_i[31:16]}
                                            : {16'h0, wb_dat_i[15:0]};
            default: lane_rdata = wb_dat_i;
        endcase
    end

    // Next-state logic. Every bus-facing output is a flop, so the bus sees
    // clean levels; bus signals are loaded only on the edge entering BUS and
    // stay frozen until the cycle terminates. Once in BUS the cycle always
    // finishes, even if the grant is withdrawn.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        size_d    = size_q;
        we_d      = we_q;
        cyc_d     = cyc_q;
        bus_we_d  = bus_we_q;
        adr_d     = adr_q;
        bus_dat_d = bus_dat_q;
        sel_d     = sel_q;
        rdata_d   = rdata_q;
        ready_d   = ready_q;
        err_d     = err_q;
        timeout_d = timeout_q;
        to_cnt_d  = to_cnt_q;

        case (state_q)
            IDLE: begin
                if (ext_tran_start_i) begin
                    addr_d  = ext_tran_addr_i;
                    wdata_d = ext_tran_data_i;
                    size_d  = ext_tran_size_i;
                    we_d    = ext_tran_write_i;
                    if (req_illegal) begin
                        state_d = DONE;
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = WAIT_GNT;
                    end
                end
            end
            WAIT_GNT: begin
                if (bus_gnt_i) begin
                    state_d   = BUS;
                    cyc_d     = 1'b1;
                    adr_d     = {addr_q[31:2], 2'b00};
                    bus_dat_d = lane_dat;
                    sel_d     = lane_sel;
                    bus_we_d  = we_q;
                    to_cnt_d  = '0;
                end
            end
            BUS: begin
                // Error has priority over a simultaneous ack.
                if (wb_err_i) begin
                    state_d = DONE;
                    cyc_d   = 1'b0;
                    ready_d = 1'b1;
                    err_d   = 1'b1;
                end else if (wb_ack_i) begin
                    state_d = DONE;
                    cyc_d   = 1'b0;
                    ready_d = 1'b1;
                    if (!we_q) begin
                        rdata_d = lane_rdata;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    state_d   = DONE;
                    cyc_d     = 1'b0;
                    ready_d   = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            DONE: begin
                // A start arriving with the clear is intentionally dropped.
                if (ext_tran_clear_i) begin
                    state_d   = IDLE;
                    ready_d   = 1'b0;
                    err_d     = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops the bus cycle immediately.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            size_q    <= '0;
            we_q      <= 1'b0;
            cyc_q     <= 1'b0;
            bus_we_q  <= 1'b0;
            adr_q     <= '0;
            bus_dat_q <= '0;
            sel_q     <= '0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
            to_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            size_q    <= size_d;
            we_q      <= we_d;
            cyc_q     <= cyc_d;
            bus_we_q  <= bus_we_d;
            adr_q     <= adr_d;
            bus_dat_q <= bus_dat_d;
            sel_q     <= sel_d;
            rdata_q   <= rdata_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    assign wb_cyc_o           = cyc_q;
    assign wb_stb_o           = cyc_q;
    assign wb_we_o            = bus_we_q;
    assign wb_adr_o           = adr_q;
    assign wb_dat_o           = bus_dat_q;
    assign wb_sel_o           = sel_q;
    assign ext_tran_data_o    = rdata_q;
    assign ext_tran_ready_o   = ready_q;
    assign ext_tran_err_o     = err_q;
    assign ext_tran_timeout_o = timeout_q;

endmodule

// File: tb/tb_ext_tran_master.sv
// ---------------------------------------------------------------------------
// tb_ext_tran_master
//
// Directed bench for ext_tran_master. The stimulus process queues the
// expected bus request and the expected transaction result; a monitor pops
// and compares them when the DUT raises wb_cyc_o or ext_tran_ready_o.
// ---------------------------------------------------------------------------
module tb_ext_tran_master;

    localparam int TIMEOUT_CYCLES = 8;
    localparam int TO_W           = 4;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        bus_gnt_i;
    logic        ext_tran_start_i;
    logic        ext_tran_write_i;
    logic [1:0]  ext_tran_size_i;
    logic [31:0] ext_tran_addr_i;
    logic [31:0] ext_tran_data_i;
    logic        ext_tran_clear_i;
    logic [31:0] ext_tran_data_o;
    logic        ext_tran_ready_o;
    logic        ext_tran_err_o;
    logic        ext_tran_timeout_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;

    typedef struct {
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic        we;
    } bus_exp_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        timeout;
    } res_exp_t;

    bus_exp_t bus_q[$];
    res_exp_t res_q[$];
    bus_exp_t bus_item;
    res_exp_t res_item;

    int   checks = 0;
    int   fails  = 0;
    logic cyc_prev = 1'b0;
    logic ready_prev = 1'b0;

    ext_tran_master #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TO_W(TO_W)
    ) dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .bus_gnt_i(bus_gnt_i),
        .ext_tran_start_i(ext_tran_start_i),
        .ext_tran_write_i(ext_tran_write_i),
        .ext_tran_size_i(ext_tran_size_i),
        .ext_tran_addr_i(ext_tran_addr_i),
        .ext_tran_data_i(ext_tran_data_i),
        .ext_tran_clear_i(ext_tran_clear_i),
        .ext_tran_data_o(ext_tran_data_o),
        .ext_tran_ready_o(ext_tran_ready_o),
        .ext_tran_err_o(ext_tran_err_o),
        .ext_tran_timeout_o(ext_tran_timeout_o),
        .wb_cyc_o(wb_cyc_o),
        .wb_stb_o(wb_stb_o),
        .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o),
        .wb_dat_o(wb_dat_o),
        .wb_sel_o(wb_sel_o),
        .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i),
        .wb_err_i(wb_err_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Pulse start for one cycle; returns just after the sampling edge.
    task automatic applyStimulus(input logic we, input logic [1:0] size,
                                 input logic [31:0] addr, input logic [31:0] data);
        ext_tran_start_i = 1'b1;
        ext_tran_write_i = we;
        ext_tran_size_i  = size;
        ext_tran_addr_i  = addr;
        ext_tran_data_i  = data;
        tick();
        ext_tran_start_i = 1'b0;
    endtask

    task automatic expectBus(input logic [31:0] adr, input logic [3:0] sel,
                             input logic [31:0] dat, input logic we);
        bus_exp_t e;
        e.adr = adr; e.sel = sel; e.dat = dat; e.we = we;
        bus_q.push_back(e);
    endtask

    task automatic expectResult(input logic [31:0] data, input logic err,
                                input logic timeout);
        res_exp_t e;
        e.data = data; e.err = err; e.timeout = timeout;
        res_q.push_back(e);
    endtask

    // Start with the grant held: cyc must be low one cycle after the start
    // edge and high on the following one.
    task automatic startToBus(input logic we, input logic [1:0] size,
                              input logic [31:0] addr, input logic [31:0] data);
        applyStimulus(we, size, addr, data);
        checkOutput("cyc_low_wait_gnt", 32'(wb_cyc_o), 32'd0);
        tick();
        checkOutput("cyc_latency", 32'(wb_cyc_o), 32'd1);
    endtask

    // Called in the first cycle with cyc high; terminates in cycle 'hold'.
    task automatic busPhase(input int hold, input logic ack, input logic errv,
                            input logic [31:0] rd);
        repeat (hold - 1) tick();
        checkOutput("cyc_held", 32'(wb_cyc_o), 32'd1);
        wb_ack_i = ack;
        wb_err_i = errv;
        wb_dat_i = rd;
        tick();
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = 32'h0;
        checkOutput("cyc_drop", 32'(wb_cyc_o), 32'd0);
        checkOutput("ready_set", 32'(ext_tran_ready_o), 32'd1);
    endtask

    task automatic clearResult();
        ext_tran_clear_i = 1'b1;
        tick();
        ext_tran_clear_i = 1'b0;
        checkOutput("ready_cleared", 32'(ext_tran_ready_o), 32'd0);
        checkOutput("err_cleared", 32'(ext_tran_err_o), 32'd0);
        checkOutput("timeout_cleared", 32'(ext_tran_timeout_o), 32'd0);
    endtask

    // Scoreboard monitor: compares on the rising edge of cyc and ready,
    // sampled mid-cycle.
    always @(negedge clk_i) begin
        if (wb_cyc_o && !cyc_prev) begin
            if (bus_q.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL unexpected_cyc: got cyc=1 adr=0x%08h, expected no bus cycle",
                         wb_adr_o);
            end else begin
                bus_item = bus_q.pop_front();
                checkOutput("bus_adr", wb_adr_o, bus_item.adr);
                checkOutput("bus_sel", 32'(wb_sel_o), 32'(bus_item.sel));
                checkOutput("bus_dat", wb_dat_o, bus_item.dat);
                checkOutput("bus_we", 32'(wb_we_o), 32'(bus_item.we));
                checkOutput("bus_stb", 32'(wb_stb_o), 32'd1);
            end
        end
        cyc_prev = wb_cyc_o;

        if (ext_tran_ready_o && !ready_prev) begin
            if (res_q.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL unexpected_ready: got ready=1, expected no result");
            end else begin
                res_item = res_q.pop_front();
                checkOutput("res_data", ext_tran_data_o, res_item.data);
                checkOutput("res_err", 32'(ext_tran_err_o), 32'(res_item.err));
                checkOutput("res_timeout", 32'(ext_tran_timeout_o), 32'(res_item.timeout));
            end
        end
        ready_prev = ext_tran_ready_o;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_i          = 1'b0;
        bus_gnt_i        = 1'b0;
        ext_tran_start_i = 1'b0;
        ext_tran_write_i = 1'b0;
        ext_tran_size_i  = 2'b00;
        ext_tran_addr_i  = 32'h0;
        ext_tran_data_i  = 32'h0;
        ext_tran_clear_i = 1'b0;
        wb_dat_i         = 32'h0;
        wb_ack_i         = 1'b0;
        wb_err_i         = 1'b0;

        tick();
        tick();
        checkOutput("rst_cyc", 32'(wb_cyc_o), 32'd0);
        checkOutput("rst_stb", 32'(wb_stb_o), 32'd0);
        checkOutput("rst_we", 32'(wb_we_o), 32'd0);
        checkOutput("rst_adr", wb_adr_o, 32'h0);
        checkOutput("rst_dat", wb_dat_o, 32'h0);
        checkOutput("rst_sel", 32'(wb_sel_o), 32'h0);
        checkOutput("rst_data_o", ext_tran_data_o, 32'h0);
        checkOutput("rst_ready", 32'(ext_tran_ready_o), 32'd0);
        checkOutput("rst_err", 32'(ext_tran_err_o), 32'd0);
        checkOutput("rst_timeout", 32'(ext_tran_timeout_o), 32'd0);
        reset_i   = 1'b1;
        bus_gnt_i = 1'b1;
        tick();

        $display("[TB] word write");
        expectBus(32'h1000_0004, 4'b1111, 32'hDEAD_BEEF, 1'b1);
        expectResult(32'h0, 1'b0, 1'b0);
        startToBus(1'b1, 2'b10, 32'h1000_0004, 32'hDEAD_BEEF);
        busPhase(4, 1'b1, 1'b0, 32'h0);
        clearResult();

        $display("[TB] byte read");
        expectBus(32'h0000_0100, 4'b1000, 32'h0, 1'b0);
        expectResult(32'h0000_00A5, 1'b0, 1'b0);
        startToBus(1'b0, 2'b00, 32'h0000_0103, 32'h0);
        busPhase(2, 1'b1, 1'b0, 32'hA500_0000);
        clearResult();
        checkOutput("data_retained_after_clear", ext_tran_data_o, 32'h0000_00A5);

        $display("[TB] half read");
        expectBus(32'h0000_0000, 4'b1100, 32'h7777_7777, 1'b0);
        expectResult(32'h0000_1234, 1'b0, 1'b0);
        startToBus(1'b0, 2'b01, 32'h0000_0002, 32'h5555_7777);
        busPhase(1, 1'b1, 1'b0, 32'h1234_ABCD);
        clearResult();

        $display("[TB] byte write");
        expectBus(32'h0000_0000, 4'b0010, 32'h3C3C_3C3C, 1'b1);
        expectResult(32'h0000_1234, 1'b0, 1'b0);
        startToBus(1'b1, 2'b00, 32'h0000_0001, 32'h0000_003C);
        busPhase(1, 1'b1, 1'b0, 32'hFFFF_FFFF);
        clearResult();

        $display("[TB] illegal requests");
        expectResult(32'h0000_1234, 1'b1, 1'b0);
        applyStimulus(1'b0, 2'b01, 32'h0000_0001, 32'h0);
        tick();
        checkOutput("illegal_half_ready", 32'(ext_tran_ready_o), 32'd1);
        checkOutput("illegal_half_err", 32'(ext_tran_err_o), 32'd1);
        checkOutput("illegal_half_cyc", 32'(wb_cyc_o), 32'd0);
        clearResult();
        expectResult(32'h0000_1234, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'b11, 32'h0000_0000, 32'h0);
        tick();
        checkOutput("illegal_size_ready", 32'(ext_tran_ready_o), 32'd1);
        checkOutput("illegal_size_err", 32'(ext_tran_err_o), 32'd1);
        clearResult();
        expectResult(32'h0000_1234, 1'b1, 1'b0);
        applyStimulus(1'b0, 2'b10, 32'h0000_0002, 32'h0);
        tick();
        checkOutput("illegal_word_err", 32'(ext_tran_err_o), 32'd1);
        clearResult();

        $display("[TB] grant and timeout");
        bus_gnt_i = 1'b0;
        expectBus(32'h0000_0200, 4'b1111, 32'h1111_1111, 1'b1);
        expectResult(32'h0000_1234, 1'b0, 1'b1);
        applyStimulus(1'b1, 2'b10, 32'h0000_0200, 32'h1111_1111);
        repeat (3) tick();
        checkOutput("cyc_no_gnt", 32'(wb_cyc_o), 32'd0);
        bus_gnt_i = 1'b1;
        tick();
        checkOutput("cyc_after_gnt", 32'(wb_cyc_o), 32'd1);
        repeat (TIMEOUT_CYCLES - 1) tick();
        checkOutput("cyc_before_timeout", 32'(wb_cyc_o), 32'd1);
        checkOutput("timeout_not_yet", 32'(ext_tran_timeout_o), 32'd0);
        tick();
        checkOutput("cyc_timeout_drop", 32'(wb_cyc_o), 32'd0);
        checkOutput("timeout_set", 32'(ext_tran_timeout_o), 32'd1);
        wb_ack_i = 1'b1;
        wb_dat_i = 32'hCAFE_CAFE;
        tick();
        wb_ack_i = 1'b0;
        wb_dat_i = 32'h0;
        checkOutput("late_ack_ready", 32'(ext_tran_ready_o), 32'd1);
        checkOutput("late_ack_timeout", 32'(ext_tran_timeout_o), 32'd1);
        checkOutput("late_ack_err", 32'(ext_tran_err_o), 32'd0);
        checkOutput("late_ack_data", ext_tran_data_o, 32'h0000_1234);
        ext_tran_start_i = 1'b1;
        ext_tran_size_i  = 2'b10;
        ext_tran_addr_i  = 32'h0000_0600;
        clearResult();
        ext_tran_start_i = 1'b0;
        tick();
        tick();
        checkOutput("start_with_clear_dropped", 32'(wb_cyc_o), 32'd0);

        $display("[TB] races");
        expectBus(32'h0000_0300, 4'b1111, 32'h2222_2222, 1'b0);
        expectResult(32'h0000_1234, 1'b1, 1'b0);
        startToBus(1'b0, 2'b10, 32'h0000_0300, 32'h2222_2222);
        bus_gnt_i = 1'b0;
        applyStimulus(1'b1, 2'b10, 32'h0000_0500, 32'h3333_3333);
        checkOutput("cyc_kept_no_gnt", 32'(wb_cyc_o), 32'd1);
        checkOutput("adr_ignores_start", wb_adr_o, 32'h0000_0300);
        checkOutput("we_ignores_start", 32'(wb_we_o), 32'd0);
        busPhase(1, 1'b1, 1'b1, 32'hFFFF_FFFF);
        checkOutput("race_err", 32'(ext_tran_err_o), 32'd1);
        bus_gnt_i = 1'b1;
        clearResult();

        $display("[TB] reset mid bus");
        expectBus(32'h0000_0400, 4'b1111, 32'hCAFE_F00D, 1'b1);
        startToBus(1'b1, 2'b10, 32'h0000_0400, 32'hCAFE_F00D);
        tick();
        #1;
        reset_i = 1'b0;
        #1;
        checkOutput("async_rst_cyc", 32'(wb_cyc_o), 32'd0);
        checkOutput("async_rst_stb", 32'(wb_stb_o), 32'd0);
        checkOutput("async_rst_ready", 32'(ext_tran_ready_o), 32'd0);
        checkOutput("async_rst_data", ext_tran_data_o, 32'h0);
        tick();
        reset_i = 1'b1;
        tick();
        tick();

        checkOutput("bus_queue_drained", 32'(bus_q.size()), 32'd0);
        checkOutput("result_queue_drained", 32'(res_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/ext_tran_master.md
Name: ext_tran_master

Overview:
Downstream stage of the FPGA-side register bridge. It consumes the external transaction request (start pulse, write flag, size, address, data, clear) and executes it as a single Wishbone classic master cycle on the SoC bus. It returns read data and a sticky ready/error status to the bridge. It only drives the bus when the bus-master selector grants it.

Parameters:
TIMEOUT_CYCLES, 1024, cycles without ack/err before the transaction is aborted with timeout status (must be >= 2).
TO_W, 11, timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
clk_i  in  1  system clock
reset_i  in  1  asynchronous reset, active low
bus_gnt_i  in  1  bus master selector; 1 = this block owns the SoC bus
ext_tran_start_i  in  1  one-cycle start pulse
ext_tran_write_i  in  1  1 = write, 0 = read
ext_tran_size_i  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
ext_tran_addr_i  in  32  byte address
ext_tran_data_i  in  32  write data, right-aligned
ext_tran_clear_i  in  1  acknowledge result; return to idle
ext_tran_data_o  out  32  read data, right-aligned, zero-extended
ext_tran_ready_o  out  1  transaction finished (sticky)
ext_tran_err_o  out  1  finished with bus error / misalign / illegal size
ext_tran_timeout_o  out  1  finished by timeout
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe
wb_we_o  out  1  Wishbone write enable
wb_adr_o  out  32  word-aligned address ({addr[31:2],2'b00})
wb_dat_o  out  32  lane-placed write data
wb_sel_o  out  4  byte selects
wb_dat_i  in  32  read data
wb_ack_i  in  1  ack
wb_err_i  in  1  error termination

Behaviour:
- Reset (async, reset_i=0): state IDLE. All outputs 0, including the wb_* outputs, data_o, ready, err, timeout, and the timeout counter.
- States: IDLE, WAIT_GNT, BUS, DONE.
- IDLE with start=1:
  - Capture addr, data, size, and we into internal registers.
  - Check legality. Illegal cases: size=11, size=01 with addr[0]=1, or size=10 with addr[1:0]!=0.
  - Illegal: go to DONE next cycle with err=1. No bus activity.
  - Legal: go to WAIT_GNT.
- Start outside IDLE is ignored; the captured registers do not change.
- WAIT_GNT: when bus_gnt_i=1, go to BUS. On the entry edge, assert cyc/stb and drive adr/dat/sel/we from the captured registers.
- Best case latency: start at cycle N, cyc high at N+2.
- Lane rules:
  - byte: sel=4'b0001<<addr[1:0], dat_o={4{data[7:0]}}.
  - half: sel=addr[1]?1100:0011, dat_o={2{data[15:0]}}.
  - word: sel=1111, dat_o=data.
- BUS: cyc/stb/adr/dat/sel/we are held stable until ack or err is sampled.
  - ack sampled at cycle M: cyc/stb low at M+1, state DONE, ready=1 at M+1.
  - On a read, the selected lanes of wb_dat_i are shifted down and zero-extended into data_o (registered at M+1).
  - On a write, data_o is unchanged.
  - err sampled: as for ack, plus err=1 and data_o unchanged.
  - ack and err in the same cycle: err wins.
- Timeout:
  - The counter clears on entering BUS and increments each BUS cycle without ack/err.
  - When it reaches TIMEOUT_CYCLES-1 with no termination: drop cyc/stb next cycle, set ready=1 and timeout=1, go to DONE.
  - A late ack after that is ignored.
- Loss of grant in BUS (bus_gnt_i falls): the cycle is completed anyway; the bus is not released mid-cycle.
- DONE: ready/err/timeout hold until clear=1. Then next cycle go to IDLE with ready=err=timeout=0; data_o retains its value.
  - Clear and start in the same DONE cycle: clear processed, start dropped.
- Clear in IDLE, WAIT_GNT, or BUS: no effect.
- Reset asserted mid-BUS: cyc/stb drop immediately (async); the transaction is lost.

Test Plan:
- Word write: gnt=1, start with addr=0x1000_0004, data=0xDEADBEEF, size=10, we=1; ack after 3 cycles → wb_adr=0x10000004, sel=1111, dat_o=0xDEADBEEF, cyc high 4 cycles, ready=1, err=0; clear → ready=0.
- Byte read: addr=0x0000_0103, size=00, wb_dat_i=0xA5000000 at ack → sel=1000, data_o=0x000000A5.
- Half read: addr=0x0000_0002, size=01, wb_dat_i=0x1234ABCD → sel=1100, data_o=0x00001234.
- Illegal requests: size=01 with addr=0x1, then size=11 → no cyc ever, ready=1 and err=1 two cycles after start.
- Grant and timeout: gnt=0 during start → cyc stays low; raise gnt → cyc high next cycle. With TIMEOUT_CYCLES=8 and no ack → cyc drops after 8 cycles, ready=1, timeout=1; a later ack has no effect.
- Races and reset: wb_err_i and wb_ack_i in the same cycle → err=1. A second start while in BUS → ignored. Assert reset_i low mid-BUS → cyc/stb/ready low with no clock edge.
